// File: rtl/moving_sum_deconv.sv
// rtl/moving_sum_deconv.sv - inverse of the 4-tap moving-sum FIR, rebuilds x[n] from y[n]
//
// Reconstructs x[n] = y[n] - y[n-1] + x[n-4] from a registered 4-tap sum stream.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   s carries a new sum sample this cycle
//   s          unsigned 4-tap moving sum, size+2 bits
//   clr        synchronous stream restart (history, y_prev, count and err cleared)
//   x          reconstructed sample, registered one cycle after acceptance
//   out_valid  single-cycle pulse per accepted sample
//   err        sticky out-of-range flag, cleared by reset or clr
//   sample_cnt accepted samples since reset/clr, saturating at 16'hFFFF

module moving_sum_deconv #(
    parameter int size = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [size+1:0] s,
    input  logic            clr,
    output logic [size-1:0] x,
    output logic            out_valid,
    output logic            err,
    output logic [15:0]     sample_cnt
);

    typedef enum logic {
        ZERO = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [size+1:0] y_prev;
    logic [size-1:0] xh [4];

    // size+3 bits holds y[n] + x[n-4] (size+2 bits plus headroom) and a sign bit.
    logic [size+2:0] y_term;
    logic [size+2:0] prev_term;
    logic [size+2:0] hist_term;
    logic [size+2:0] d;
    logic            fresh;
    logic            out_of_range;

    always_comb begin
        // A sample is "fresh" when it starts a stream: either clr is restarting
        // the stream this cycle, or nothing has been accepted since reset/clr.
        fresh        = clr || (state == ZERO);
        y_term       = {1'b0, s};
        prev_term    = fresh ? '0 : {1'b0, y_prev};
        hist_term    = fresh ? '0 : {3'b000, xh[3]};
        d            = y_term - prev_term + hist_term;
        // Negative (sign bit) or above 2^size-1 (any bit at or above size).
        out_of_range = |d[size+2:size];

        state_next = state;
        if (in_valid) begin
            state_next = RUN;
        end else if (clr) begin
            state_next = ZERO;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ZERO;
            x          <= '0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            sample_cnt <= '0;
            y_prev     <= '0;
            for (int i = 0; i < 4; i++) begin
                xh[i] <= '0;
            end
        end else begin
            state     <= state_next;
            out_valid <= in_valid;

            if (clr) begin
                err        <= 1'b0;
                sample_cnt <= '0;
                y_prev     <= '0;
                for (int i = 0; i < 4; i++) begin
                    xh[i] <= '0;
                end
            end

            // Later assignments override the clr defaults, so a sample arriving
            // with clr becomes the first sample of the new stream.
            if (in_valid) begin
                x      <= d[size-1:0];
                y_prev <= s;
                xh[0]  <= d[size-1:0];
                xh[1]  <= fresh ? '0 : xh[0];
                xh[2]  <= fresh ? '0 : xh[1];
                xh[3]  <= fresh ? '0 : xh[2];
                if (out_of_range) begin
                    err <= 1'b1;
                end
                if (fresh) begin
                    sample_cnt <= 16'd1;
                end else if (sample_cnt != 16'hFFFF) begin
                    sample_cnt <= sample_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_moving_sum_deconv.sv
// tb/tb_moving_sum_deconv.sv - table-driven self-checking bench for moving_sum_deconv

module tb_moving_sum_deconv;

    localparam int SIZE = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [SIZE+1:0] s;
    logic            clr;
    logic [SIZE-1:0] x;
    logic            out_valid;
    logic            err;
    logic [15:0]     sample_cnt;

    moving_sum_deconv #(.size(SIZE)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .s          (s),
        .clr        (clr),
        .x          (x),
        .out_valid  (out_valid),
        .err        (err),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            iv;
        logic            cl;
        logic [SIZE+1:0] sv;
        logic            ov;
        logic [SIZE-1:0] ex;
        logic            ee;
        logic [15:0]     ec;
    } vec_t;

    typedef struct {
        int              idx;
        logic            ov;
        logic [SIZE-1:0] ex;
        logic            ee;
        logic [15:0]     ec;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic rst, input logic iv, input logic cl, input logic [SIZE+1:0] sv,
                       input logic ov, input logic [SIZE-1:0] ex, input logic ee, input logic [15:0] ec);
        vec_t v;
        v.rst = rst; v.iv = iv; v.cl = cl; v.sv = sv;
        v.ov = ov; v.ex = ex; v.ee = ee; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input exp_t e);
        n_vec++;
        if (out_valid !== e.ov || x !== e.ex || err !== e.ee || sample_cnt !== e.ec) begin
            n_bad++;
            $display("FAIL %s[%0d]: got ov=%0b x=%h err=%0b cnt=%h, expected ov=%0b x=%h err=%0b cnt=%h",
                     name, e.idx, out_valid, x, err, sample_cnt, e.ov, e.ex, e.ee, e.ec);
        end
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; in_valid = 1'b0; s = '0; clr = 1'b0;

        //   rst iv  cl  s          ov  x         err cnt
        // reset state
        add(1, 0, 0, 18'd0,      0, 16'd0,     0, 16'd0);
        add(0, 0, 0, 18'd0,      0, 16'd0,     0, 16'd0);
        // basic ramp
        add(0, 1, 0, 18'd1,      1, 16'd1,     0, 16'd1);
        add(0, 1, 0, 18'd3,      1, 16'd2,     0, 16'd2);
        add(0, 1, 0, 18'd6,      1, 16'd3,     0, 16'd3);
        add(0, 1, 0, 18'd10,     1, 16'd4,     0, 16'd4);
        add(0, 1, 0, 18'd14,     1, 16'd5,     0, 16'd5);
        add(0, 0, 0, 18'd0,      0, 16'd5,     0, 16'd5);
        // clr alone, then the ramp with gaps; x holds across gaps
        add(0, 0, 1, 18'd0,      0, 16'd5,     0, 16'd0);
        add(0, 1, 0, 18'd1,      1, 16'd1,     0, 16'd1);
        add(0, 0, 0, 18'd99,     0, 16'd1,     0, 16'd1);
        add(0, 0, 0, 18'd77,     0, 16'd1,     0, 16'd1);
        add(0, 1, 0, 18'd3,      1, 16'd2,     0, 16'd2);
        add(0, 0, 0, 18'd0,      0, 16'd2,     0, 16'd2);
        add(0, 0, 0, 18'd0,      0, 16'd2,     0, 16'd2);
        add(0, 1, 0, 18'd6,      1, 16'd3,     0, 16'd3);
        add(0, 0, 0, 18'd0,      0, 16'd3,     0, 16'd3);
        add(0, 1, 0, 18'd10,     1, 16'd4,     0, 16'd4);
        add(0, 1, 0, 18'd14,     1, 16'd5,     0, 16'd5);
        // clr together with a sample restarts against zero history
        add(0, 1, 1, 18'd7,      1, 16'd7,     0, 16'd1);
        add(0, 1, 0, 18'd9,      1, 16'd2,     0, 16'd2);
        // inconsistent input: negative d, sticky err until clr
        add(0, 0, 1, 18'd0,      0, 16'd2,     0, 16'd0);
        add(0, 1, 0, 18'd5,      1, 16'd5,     0, 16'd1);
        add(0, 1, 0, 18'd2,      1, 16'hFFFD,  1, 16'd2);
        add(0, 1, 0, 18'd2,      1, 16'd0,     1, 16'd3);
        add(0, 0, 0, 18'd0,      0, 16'd0,     1, 16'd3);
        add(0, 0, 1, 18'd0,      0, 16'd0,     0, 16'd0);
        // first sample above 2^size-1 flags err, x truncated
        add(0, 1, 1, 18'h10000,  1, 16'd0,     1, 16'd1);
        add(0, 0, 1, 18'd0,      0, 16'd0,     0, 16'd0);
        // full scale
        add(0, 1, 0, 18'h0FFFF,  1, 16'hFFFF,  0, 16'd1);
        add(0, 1, 0, 18'h1FFFE,  1, 16'hFFFF,  0, 16'd2);
        add(0, 1, 0, 18'h2FFFD,  1, 16'hFFFF,  0, 16'd3);
        add(0, 1, 0, 18'h3FFFC,  1, 16'hFFFF,  0, 16'd4);
        add(0, 1, 0, 18'h3FFFC,  1, 16'hFFFF,  0, 16'd5);
        // reset mid-stream drops the sample offered with it, then restart
        add(1, 1, 0, 18'd123,    0, 16'd0,     0, 16'd0);
        add(0, 1, 0, 18'd4,      1, 16'd4,     0, 16'd1);
        add(0, 1, 0, 18'd9,      1, 16'd5,     0, 16'd2);
        add(0, 0, 0, 18'd0,      0, 16'd5,     0, 16'd2);

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            reset    = vecs[i].rst;
            in_valid = vecs[i].iv;
            clr      = vecs[i].cl;
            s        = vecs[i].sv;
            e.idx = i; e.ov = vecs[i].ov; e.ex = vecs[i].ex; e.ee = vecs[i].ee; e.ec = vecs[i].ec;
            sb.push_back(e);
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL scoreboard: empty queue at vector %0d", i);
            end else begin
                check("vec", sb.pop_front());
            end
        end

        // sample_cnt saturation: 65536 zero samples after clr, x stays 0
        reset = 1'b0; clr = 1'b1; in_valid = 1'b0; s = '0;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b1; s = '0;
        for (int k = 0; k < 65536; k++) begin
            @(posedge clk);
        end
        #1;
        e.idx = 0; e.ov = 1'b1; e.ex = '0; e.ee = 1'b0; e.ec = 16'hFFFF;
        check("sat", e);
        @(posedge clk); #1;
        e.idx = 1;
        check("sat", e);
        in_valid = 1'b0;
        @(posedge clk); #1;
        e.idx = 2; e.ov = 1'b0;
        check("sat", e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
